// File: rtl/pit_rw_control.sv
// pit_rw_control
// Bus-side read/write logic of an 8254-style programmable interval timer.
// Decodes CPU strobes, captures per-counter control words, sequences
// LSB/MSB count loads toward the counter channels, and returns live or
// latched count bytes on reads.
//
// Ports:
//   clk, rst     - clock (rising edge), synchronous active-high reset
//   cs_n         - chip select, active low
//   wr_n, rd_n   - write / read strobes, active low
//   addr         - 0..2 select counter 0..2, 3 selects the control register
//   data_in      - CPU write data
//   data_out     - registered CPU read data
//   data_oe      - registered read-data valid / bus drive enable
//   ctrl_word    - per-counter {RW[1:0],M[2:0],BCD}, counter n at [6n+5:6n]
//   ctrl_wr      - one-cycle pulse per counter when its control word changes
//   count_data   - count byte being loaded (holds until next load)
//   data_en      - one-cycle pulse per counter, count_data valid that cycle
//   count_in     - live 16-bit counts, counter n at [16n+15:16n]
module pit_rw_control #(
  parameter int DATA_W  = 8,
  parameter int NUM_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  wr_n,
  input  logic                  rd_n,
  input  logic [1:0]            addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_oe,
  output logic [6*NUM_CNT-1:0]  ctrl_word,
  output logic [NUM_CNT-1:0]    ctrl_wr,
  output logic [DATA_W-1:0]     count_data,
  output logic [NUM_CNT-1:0]    data_en,
  input  logic [16*NUM_CNT-1:0] count_in
);

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_BOTH  = 2'b11
  } rw_e;

  localparam logic [1:0] CTRL_ADDR = 2'd3;

  logic [NUM_CNT-1:0][5:0]  cw;
  logic [NUM_CNT-1:0][15:0] live;
  logic [NUM_CNT-1:0][15:0] latch_reg;
  logic [NUM_CNT-1:0]       latch_valid;
  logic [NUM_CNT-1:0]       wtog;
  logic [NUM_CNT-1:0]       rtog;
  logic                     wr_d;
  logic                     rd_d;

  logic                     wr_ev;
  logic                     rd_ev;
  logic                     is_cnt;
  logic [1:0]               sc;
  rw_e                      new_rw;
  rw_e                      cur_rw;
  logic [15:0]              rd_src;
  logic [DATA_W-1:0]        rd_byte;

  assign ctrl_word = cw;
  assign live      = count_in;

  // Edge detection on the registered strobes: a write fires once on the
  // falling edge of wr_n, a read completes on the rising edge of rd_n.
  assign wr_ev  = wr_d & ~wr_n & ~cs_n;
  assign rd_ev  = ~rd_d & rd_n & ~cs_n;
  assign is_cnt = (addr != CTRL_ADDR);
  assign sc     = data_in[7:6];
  assign new_rw = rw_e'(data_in[5:4]);

  // NOTE: every variable gets a default before any branch so no latch is
  // inferred when addr selects the control register.
  always_comb begin
    cur_rw  = RW_LATCH;
    rd_src  = '0;
    rd_byte = '0;
    if (is_cnt) begin
      cur_rw = rw_e'(cw[addr][5:4]);
      rd_src = latch_valid[addr] ? latch_reg[addr] : live[addr];
      unique case (cur_rw)
        RW_LSB:   rd_byte = rd_src[7:0];
        RW_MSB:   rd_byte = rd_src[15:8];
        RW_BOTH:  rd_byte = rtog[addr] ? rd_src[15:8] : rd_src[7:0];
        default:  rd_byte = '0;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_d        <= 1'b1;
      rd_d        <= 1'b1;
      data_out    <= '0;
      data_oe     <= 1'b0;
      cw          <= '0;
      ctrl_wr     <= '0;
      count_data  <= '0;
      data_en     <= '0;
      wtog        <= '0;
      rtog        <= '0;
      latch_valid <= '0;
      // NOTE: the latch storage is tiny, so it is cleared outright rather
      // than relying on latch_valid alone to mask stale contents.
      latch_reg   <= '0;
    end else begin
      wr_d     <= wr_n;
      rd_d     <= rd_n;
      ctrl_wr  <= '0;
      data_en  <= '0;
      data_oe  <= ~cs_n & ~rd_n & wr_n;
      data_out <= rd_byte;

      if (rd_ev && is_cnt) begin
        unique case (cur_rw)
          RW_BOTH: begin
            rtog[addr] <= ~rtog[addr];
            if (rtog[addr]) latch_valid[addr] <= 1'b0;  // MSB just read
          end
          RW_LSB, RW_MSB: latch_valid[addr] <= 1'b0;
          default: ;
        endcase
      end

      // Placed after the read handling so a control write that clears the
      // toggles/latch wins over a coincident read completion.
      if (wr_ev) begin
        if (!is_cnt) begin
          if (sc != 2'd3) begin
            if (new_rw == RW_LATCH) begin
              if (!latch_valid[sc]) begin
                latch_reg[sc]   <= live[sc];
                latch_valid[sc] <= 1'b1;
              end
            end else begin
              cw[sc]          <= data_in[5:0];
              ctrl_wr[sc]     <= 1'b1;
              wtog[sc]        <= 1'b0;
              rtog[sc]        <= 1'b0;
              latch_valid[sc] <= 1'b0;
            end
          end
        end else begin
          unique case (cur_rw)
            RW_LSB, RW_MSB: begin
              count_data    <= data_in;
              data_en[addr] <= 1'b1;
            end
            RW_BOTH: begin
              count_data    <= data_in;
              data_en[addr] <= 1'b1;
              wtog[addr]    <= ~wtog[addr];
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pit_rw_control.sv
// Directed testbench for pit_rw_control. Inputs are driven on the falling
// clock edge and outputs sampled on the falling edge.
module tb_pit_rw_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        wr_n;
  logic        rd_n;
  logic [1:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [17:0] ctrl_word;
  logic [2:0]  ctrl_wr;
  logic [7:0]  count_data;
  logic [2:0]  data_en;
  logic [47:0] count_in;

  int checks = 0;
  int errors = 0;

  pit_rw_control dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .wr_n       (wr_n),
    .rd_n       (rd_n),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .ctrl_word  (ctrl_word),
    .ctrl_wr    (ctrl_wr),
    .count_data (count_data),
    .data_en    (data_en),
    .count_in   (count_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  // One short write pulse; captures the pulse outputs in the cycle after
  // the detecting edge and the pulses one cycle later.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d,
                           output logic [2:0] en, output logic [7:0] cd,
                           output logic [2:0] cw, output logic [5:0] after);
    @(negedge clk);
    cs_n = 1'b0; addr = a; data_in = d; wr_n = 1'b0;
    @(negedge clk);
    en = data_en; cd = count_data; cw = ctrl_wr;
    wr_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    after = {data_en, ctrl_wr};
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk);
    cs_n = 1'b0; addr = a; rd_n = 1'b0;
    @(negedge clk);
    d = data_out; oe = data_oe;
    rd_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({data_out, data_oe, ctrl_word, ctrl_wr, count_data, data_en} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {data_out, data_oe, ctrl_word, ctrl_wr, count_data, data_en});
    end
  endtask

  task automatic test_ctrl_write;
    logic [2:0] en, cw; logic [7:0] cd; logic [5:0] after;
    cpu_write(2'd3, 8'h36, en, cd, cw, after);
    checks++;
    if (cw !== 3'b001) begin errors++; $display("FAIL ctrl_wr_pulse: got %b expected 001", cw); end
    checks++;
    if (after !== 6'd0) begin errors++; $display("FAIL ctrl_wr_width: got %b expected 0", after); end
    checks++;
    if (ctrl_word !== 18'h00036) begin errors++; $display("FAIL ctrl_word_36: got %h expected 00036", ctrl_word); end
  endtask

  task automatic test_count_both;
    logic [2:0] en, cw; logic [7:0] cd; logic [5:0] after;
    cpu_write(2'd0, 8'h34, en, cd, cw, after);
    checks++;
    if ({en, cd} !== {3'b001, 8'h34}) begin errors++; $display("FAIL lsb_load: got en=%b cd=%h expected en=001 cd=34", en, cd); end
    cpu_write(2'd0, 8'h12, en, cd, cw, after);
    checks++;
    if ({en, cd} !== {3'b001, 8'h12}) begin errors++; $display("FAIL msb_load: got en=%b cd=%h expected en=001 cd=12", en, cd); end
    checks++;
    if ({after, count_data} !== {6'd0, 8'h12}) begin errors++; $display("FAIL load_hold: got pulses=%b cd=%h expected 0 / 12", after, count_data); end
  endtask

  task automatic test_single_byte;
    logic [2:0] en, cw; logic [7:0] cd, d; logic [5:0] after; logic oe;
    cpu_write(2'd3, 8'h50, en, cd, cw, after);
    checks++;
    if ({cw, ctrl_word} !== {3'b010, 18'h00436}) begin errors++; $display("FAIL ctrl_cnt1: got wr=%b word=%h expected 010 / 00436", cw, ctrl_word); end
    cpu_write(2'd1, 8'h7F, en, cd, cw, after);
    checks++;
    if ({en, cd} !== {3'b010, 8'h7F}) begin errors++; $display("FAIL cnt1_load: got en=%b cd=%h expected 010 / 7f", en, cd); end
    cpu_write(2'd1, 8'h80, en, cd, cw, after);
    checks++;
    if ({en, cd} !== {3'b010, 8'h80}) begin errors++; $display("FAIL cnt1_repeat: got en=%b cd=%h expected 010 / 80", en, cd); end
    count_in[31:16] = 16'h5A6B;
    cpu_read(2'd1, d, oe);
    checks++;
    if ({oe, d} !== {1'b1, 8'h6B}) begin errors++; $display("FAIL cnt1_read_lsb: got oe=%b d=%h expected 1 / 6b", oe, d); end
    cpu_read(2'd3, d, oe);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ctrl_addr_read: got %h expected 00", d); end
    count_in[47:32] = 16'hFFFF;
    cpu_read(2'd2, d, oe);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL unprog_read: got %h expected 00", d); end
  endtask

  task automatic test_latch;
    logic [2:0] en, cw; logic [7:0] cd, d; logic [5:0] after; logic oe;
    count_in[15:0] = 16'hABCD;
    cpu_write(2'd3, 8'h00, en, cd, cw, after);
    checks++;
    if ({cw, ctrl_word} !== {3'b000, 18'h00436}) begin errors++; $display("FAIL latch_no_ctrl: got wr=%b word=%h expected 000 / 00436", cw, ctrl_word); end
    count_in[15:0] = 16'h1111;
    cpu_read(2'd0, d, oe);
    checks++;
    if (d !== 8'hCD) begin errors++; $display("FAIL latch_lsb: got %h expected cd", d); end
    cpu_read(2'd0, d, oe);
    checks++;
    if (d !== 8'hAB) begin errors++; $display("FAIL latch_msb: got %h expected ab", d); end
    cpu_read(2'd0, d, oe);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL live_after_latch: got %h expected 11", d); end
    cpu_read(2'd0, d, oe);  // MSB of live value, returns rtog to LSB
  endtask

  task automatic test_double_latch;
    logic [2:0] en, cw; logic [7:0] cd, d; logic [5:0] after; logic oe;
    count_in[15:0] = 16'h2222;
    cpu_write(2'd3, 8'h00, en, cd, cw, after);
    count_in[15:0] = 16'h3344;
    cpu_write(2'd3, 8'h00, en, cd, cw, after);
    cpu_read(2'd0, d, oe);
    checks++;
    if (d !== 8'h22) begin errors++; $display("FAIL relatch_lsb: got %h expected 22", d); end
    cpu_read(2'd0, d, oe);
    checks++;
    if (d !== 8'h22) begin errors++; $display("FAIL relatch_msb: got %h expected 22", d); end
    cpu_read(2'd0, d, oe);
    checks++;
    if (d !== 8'h44) begin errors++; $display("FAIL relatch_live: got %h expected 44", d); end
  endtask

  task automatic test_reset_mid;
    logic [2:0] en, cw; logic [7:0] cd; logic [5:0] after;
    cpu_write(2'd3, 8'h36, en, cd, cw, after);
    cpu_write(2'd0, 8'h55, en, cd, cw, after);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({data_out, data_oe, ctrl_word, ctrl_wr, count_data, data_en} !== 45'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {data_out, data_oe, ctrl_word, ctrl_wr, count_data, data_en});
    end
    cpu_write(2'd0, 8'h99, en, cd, cw, after);
    checks++;
    if ({en, cd, ctrl_word} !== {3'b000, 8'h00, 18'h0}) begin
      errors++;
      $display("FAIL write_after_reset: got en=%b cd=%h word=%h expected 000 / 00 / 0", en, cd, ctrl_word);
    end
  endtask

  task automatic test_long_write;
    logic [2:0] en, cw; logic [7:0] cd; logic [5:0] after;
    int pulses;
    cpu_write(2'd3, 8'h36, en, cd, cw, after);
    pulses = 0;
    @(negedge clk);
    cs_n = 1'b0; addr = 2'd0; data_in = 8'h42; wr_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (data_en[0]) pulses++;
    end
    wr_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    if (data_en[0]) pulses++;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL long_write_pulses: got %0d expected 1", pulses); end
    checks++;
    if (count_data !== 8'h42) begin errors++; $display("FAIL long_write_data: got %h expected 42", count_data); end
  endtask

  task automatic test_wr_rd_overlap;
    @(negedge clk);
    cs_n = 1'b0; addr = 2'd0; data_in = 8'h24; wr_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if ({data_en, count_data} !== {3'b001, 8'h24}) begin
          errors++;
          $display("FAIL overlap_write: got en=%b cd=%h expected 001 / 24", data_en, count_data);
        end
      end
      checks++;
      if (data_oe !== 1'b0) begin errors++; $display("FAIL overlap_oe_%0d: got %b expected 0", i, data_oe); end
    end
    wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    addr = 2'd0; data_in = 8'h00; count_in = 48'h0;
    test_reset();
    test_ctrl_write();
    test_count_both();
    test_single_byte();
    test_latch();
    test_double_latch();
    test_reset_mid();
    test_long_write();
    test_wr_rd_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
